// File: rtl/hc_sr04_scheduler.sv
// Round-robin scheduler sharing one hc_sr04 core across N sensors: trigger demux, gated echo mux, timeouts, guard gap.
// Latency: enable to trigger 2 cycles, echo pin to core 3 cycles, busy fall to result 1 cycle; no backpressure, results are strobes.
module hc_sr04_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int ARM_CYCLES     = 50_000,
  parameter int TIMEOUT_CYCLES = 1_900_000,
  parameter int GUARD_CYCLES   = 3_000_000,
  localparam int CH_W          = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] channel_mask,
  output logic [N_SENSORS-1:0] trig_out,
  input  logic [N_SENSORS-1:0] echo_in,
  output logic                 core_trigger,
  output logic                 core_echo,
  input  logic                 core_busy,
  input  logic [31:0]          core_range,
  output logic [31:0]          result_range,
  output logic [CH_W-1:0]      result_channel,
  output logic [1:0]           result_status,
  output logic                 result_valid,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_TRIG,
    S_ARM,
    S_MEASURE,
    S_FLUSH,
    S_GUARD
  } state_t;

  localparam logic [1:0]  ST_OK       = 2'b00;
  localparam logic [1:0]  ST_NO_START = 2'b01;
  localparam logic [1:0]  ST_TIMEOUT  = 2'b10;

  localparam logic [31:0] TRIG_LOAD    = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] ARM_LOAD     = 32'(ARM_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GUARD_LOAD   = 32'(GUARD_CYCLES - 1);

  state_t                 state, state_next;
  logic [31:0]            cnt, cnt_next;
  logic [CH_W-1:0]        last_ch, last_next;
  logic [1:0]             err_status, err_status_next;
  logic [N_SENSORS-1:0]   echo_meta, echo_sync;
  logic [N_SENSORS-1:0]   trig_next;
  logic                   gate;
  logic                   strobe, strobe_err;
  logic                   found;
  logic [CH_W-1:0]        pick;
  logic [CH_W:0]          probe;

  // Next participating channel after the last-served one, searching upward with wrap.
  always_comb begin
    found = 1'b0;
    pick  = last_ch;
    probe = '0;
    for (int i = 1; i <= N_SENSORS; i++) begin
      probe = {1'b0, last_ch} + (CH_W+1)'(i);
      if (probe >= (CH_W+1)'(N_SENSORS)) probe = probe - (CH_W+1)'(N_SENSORS);
      if (!found && channel_mask[probe[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = probe[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_next      = state;
    last_next       = last_ch;
    err_status_next = err_status;
    strobe          = 1'b0;
    strobe_err      = 1'b0;
    case (state)
      S_IDLE:    if (enable && (channel_mask != '0)) state_next = S_SELECT;
      S_SELECT: begin
        if (found) begin
          last_next  = pick;
          state_next = S_TRIG;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_TRIG:    if (cnt == 32'd0) state_next = S_ARM;
      S_ARM: begin
        if (core_busy) begin
          state_next = S_MEASURE;
        end else if (cnt == 32'd0) begin
          err_status_next = ST_NO_START;
          state_next      = S_FLUSH;
        end
      end
      S_MEASURE: begin
        if (!core_busy) begin
          strobe     = 1'b1;
          state_next = S_GUARD;
        end else if (cnt == 32'd0) begin
          err_status_next = ST_TIMEOUT;
          state_next      = S_FLUSH;
        end
      end
      // Echo is gated off here so the core sees a falling edge and ends its measurement.
      S_FLUSH: begin
        if (!core_busy) begin
          strobe     = 1'b1;
          strobe_err = 1'b1;
          state_next = S_GUARD;
        end
      end
      S_GUARD:   if (cnt == 32'd0) state_next = enable ? S_SELECT : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_next = cnt;
    if (state_next != state) begin
      case (state_next)
        S_TRIG:    cnt_next = TRIG_LOAD;
        S_ARM:     cnt_next = ARM_LOAD;
        S_MEASURE: cnt_next = TIMEOUT_LOAD;
        S_GUARD:   cnt_next = GUARD_LOAD;
        default:   cnt_next = '0;
      endcase
    end else if (cnt != 32'd0) begin
      cnt_next = cnt - 32'd1;
    end
  end

  always_comb begin
    trig_next = '0;
    if (state_next == S_TRIG) trig_next[last_next] = 1'b1;
  end

  assign gate = (state == S_ARM) || (state == S_MEASURE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_ch    <= CH_W'(N_SENSORS - 1);
      err_status <= ST_OK;
      echo_meta  <= '0;
      echo_sync  <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      last_ch    <= last_next;
      err_status <= err_status_next;
      echo_meta  <= echo_in;
      echo_sync  <= echo_meta;
    end
  end

  // Pin-facing outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      trig_out       <= '0;
      core_trigger   <= 1'b0;
      core_echo      <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_range   <= '0;
      result_channel <= '0;
      result_status  <= ST_OK;
    end else begin
      trig_out     <= trig_next;
      core_trigger <= (state_next == S_TRIG);
      core_echo    <= echo_sync[last_ch] & gate;
      busy         <= (state_next != S_IDLE);
      result_valid <= strobe;
      if (strobe) begin
        result_range   <= strobe_err ? 32'hFFFF_FFFF : core_range;
        result_channel <= last_ch;
        result_status  <= strobe_err ? err_status : ST_OK;
      end
    end
  end

endmodule
